fir_coef_sequencer: RTL and testbench

Time-multiplexed controller that generates the windowless low-pass FIR coefficients hd[n] = sin(w_c·n)/(π·n), with hd[0] = w_c/π, for n = −HALF..+HALF. It uses one shared fpmul and one shared sine pipeline (sin_arg_adjust + sinecalculator) instead of one instance per tap. It sits between the cutoff register (w_c) and the FIR coefficient bank. Coefficients are emitted as an indexed stream with start/busy/done handshake.

---
 rtl/fir_coef_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_fir_coef_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_sequencer.sv
// fir_coef_sequencer: time-multiplexed generator of windowless low-pass FIR
// coefficients hd[n] = sin(w_c*n)/(pi*n), hd[0] = w_c/pi, for n = -HALF..+HALF.
// A single external fpmul and a single external sine pipeline are shared by
// all taps. Coefficients leave as an indexed stream (coef_valid/coef_idx).
// The reset input is active-low and asynchronous despite its name.
// Optional feature macro: FIR_SEQ_SYMMETRY_EN computes only n = -HALF..0 and
// emits each negative-n coefficient a second time at its mirrored index.
module fir_coef_sequencer #(
  parameter int HALF     = 6,
  parameter int SINE_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] w_c,
  output logic        busy,
  output logic        done,
  output logic        coef_valid,
  output logic [3:0]  coef_idx,
  output logic [31:0] coef_data,
  output logic [4:0]  err_flags,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p,
  input  logic [4:0]  mul_flags,
  output logic [31:0] sin_arg,
  output logic        sin_en,
  input  logic [31:0] sin_res
);

  localparam logic [31:0]        ONE_OVER_PI = 32'h3EA2F983;
  localparam logic signed [3:0]  HALF_S      = 4'(HALF);
  localparam logic signed [3:0]  N_FIRST     = -HALF_S;
  localparam logic [7:0]         LAT_LAST    = 8'(SINE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARG,
    SIN,
    SCALE,
    CENTER,
    EMIT,
    MIRROR,
    DONE
  } state_t;

  state_t            state;
  logic signed [3:0] n;
  logic signed [3:0] n_inc;
  logic [31:0]       w_reg;
  logic [7:0]        lat_cnt;

  // Magnitude of the tap offset, used as the ROM address (1..6).
  function automatic logic [2:0] mag(input logic signed [3:0] v);
    return v[3] ? 3'(-v) : 3'(v);
  endfunction

  // float(n): the ROM stores -k; positive n flips the sign bit.
  function automatic logic [31:0] n_f_rom(input logic signed [3:0] v);
    logic [31:0] r;
    case (mag(v))
      3'd1:    r = 32'hBF800000;
      3'd2:    r = 32'hC0000000;
      3'd3:    r = 32'hC0400000;
      3'd4:    r = 32'hC0800000;
      3'd5:    r = 32'hC0A00000;
      3'd6:    r = 32'hC0C00000;
      default: r = 32'h00000000;
    endcase
    r[31] = r[31] ^ ~v[3];
    return r;
  endfunction

  // 1/(pi*n): the ROM stores 1/(pi*(-k)); positive n flips the sign bit.
  function automatic logic [31:0] hd_div_rom(input logic signed [3:0] v);
    logic [31:0] r;
    case (mag(v))
      3'd1:    r = 32'hBEA2F983;
      3'd2:    r = 32'hBE22F983;
      3'd3:    r = 32'hBDD94CAF;
      3'd4:    r = 32'hBDA2F983;
      3'd5:    r = 32'hBD826136;
      3'd6:    r = 32'hBD594CAF;
      default: r = 32'h00000000;
    endcase
    r[31] = r[31] ^ ~v[3];
    return r;
  endfunction

  // Next tap offset, shared by the EMIT and MIRROR advance paths.
  assign n_inc = n + 4'sd1;

  // Sequencer FSM; every output is registered and set on entry to the state
  // that owns it. The sin_arg register doubles as the argument register, the
  // mul_a register holds the sampled sine in SCALE, and coef_data is the
  // coefficient register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      n          <= '0;
      w_reg      <= '0;
      lat_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      coef_valid <= 1'b0;
      coef_idx   <= '0;
      coef_data  <= '0;
      err_flags  <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      sin_arg    <= '0;
      sin_en     <= 1'b0;
    end else begin
      coef_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_reg     <= w_c;
            err_flags <= '0;
            n         <= N_FIRST;
            busy      <= 1'b1;
            mul_a     <= w_c;
            mul_b     <= n_f_rom(N_FIRST);
            state     <= ARG;
          end
        end
        ARG: begin
          err_flags <= err_flags | mul_flags;
          sin_arg   <= mul_p;
          sin_en    <= 1'b1;
          mul_a     <= '0;
          mul_b     <= '0;
          lat_cnt   <= '0;
          state     <= SIN;
        end
        SIN: begin
          if (lat_cnt == LAT_LAST) begin
            sin_arg <= '0;
            sin_en  <= 1'b0;
            mul_a   <= sin_res;
            mul_b   <= hd_div_rom(n);
            state   <= SCALE;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        SCALE, CENTER: begin
          err_flags  <= err_flags | mul_flags;
          coef_data  <= mul_p;
          coef_valid <= 1'b1;
          coef_idx   <= $unsigned(n + HALF_S);
          mul_a      <= '0;
          mul_b      <= '0;
          state      <= EMIT;
        end
`ifdef FIR_SEQ_SYMMETRY_EN
        EMIT: begin
          if (n[3]) begin
            coef_valid <= 1'b1;
            coef_idx   <= $unsigned(HALF_S - n);
            state      <= MIRROR;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        MIRROR: begin
          n     <= n_inc;
          mul_a <= w_reg;
          mul_b <= (n_inc == 4'sd0) ? ONE_OVER_PI : n_f_rom(n_inc);
          state <= (n_inc == 4'sd0) ? CENTER : ARG;
        end
`else
        EMIT: begin
          if (n == HALF_S) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            n     <= n_inc;
            mul_a <= w_reg;
            mul_b <= (n_inc == 4'sd0) ? ONE_OVER_PI : n_f_rom(n_inc);
            state <= (n_inc == 4'sd0) ? CENTER : ARG;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          sin_en  <= 1'b0;
          sin_arg <= '0;
          mul_a   <= '0;
          mul_b   <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Testbench for fir_coef_sequencer: behavioural fpmul and ideal sine pipeline,
// scoreboard of expected {idx, coef} records, table of cutoff vectors plus
// hand-written sequences for ignored starts and reset mid-run.
// Honours FIR_SEQ_SYMMETRY_EN for the expected order and done latency.
`timescale 1ns/1ps
module tb_fir_coef_sequencer;

  localparam int  HALF     = 6;
  localparam int  SINE_LAT = 4;
  localparam real PI       = 3.14159265358979323846;
`ifdef FIR_SEQ_SYMMETRY_EN
  localparam int  EXP_DONE = HALF * (SINE_LAT + 4) + 3;
  localparam int  RST_OFS  = 27;
`else
  localparam int  EXP_DONE = 2 * HALF * (SINE_LAT + 3) + 3;
  localparam int  RST_OFS  = 24;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] w_c;
  logic        busy, done, coef_valid, sin_en;
  logic [3:0]  coef_idx;
  logic [31:0] coef_data, mul_a, mul_b, mul_p, sin_arg, sin_res;
  logic [4:0]  err_flags, mul_flags;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int start_cyc = 0;
  logic [4:0] exp_err;
  logic zero_mode = 1'b0;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] w;
    logic        zero_run;
  } vec_t;
  vec_t vecs[4];

  fir_coef_sequencer #(.HALF(HALF), .SINE_LAT(SINE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .w_c(w_c),
    .busy(busy), .done(done), .coef_valid(coef_valid), .coef_idx(coef_idx),
    .coef_data(coef_data), .err_flags(err_flags), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_flags(mul_flags), .sin_arg(sin_arg), .sin_en(sin_en),
    .sin_res(sin_res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          ex;
    logic [24:0] man;
    logic        g, st;
    d  = $realtobits(r);
    ex = int'(d[62:52]) - 1023 + 127;
    if (d[62:52] == 11'd0 || ex <= 0) return {d[63], 31'd0};
    man = {2'b01, d[51:29]};
    g   = d[28];
    st  = |d[27:0];
    if (g && (st || man[0])) man = man + 25'd1;
    if (man[24]) begin
      man = man >> 1;
      ex++;
    end
    if (ex >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], ex[7:0], man[22:0]};
  endfunction

  task automatic tbMul(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] p, output logic inexact);
    real prod;
    prod    = f2r(a) * f2r(b);
    p       = r2f(prod);
    inexact = (f2r(p) != prod);
  endtask

  function automatic logic [31:0] fsin(input logic [31:0] x);
    return r2f($sin(f2r(x)));
  endfunction

  // Shared combinational fpmul; flag bit 0 reports an inexact product.
  always_comb begin
    logic [31:0] p;
    logic        ix;
    tbMul(mul_a, mul_b, p, ix);
    mul_p     = p;
    mul_flags = {4'b0000, ix};
  end

  // Sine pipeline: result of an argument presented in cycle t is valid in cycle t+SINE_LAT-1.
  logic [31:0] sin_pipe [SINE_LAT-1];
  always @(posedge clk) begin
    sin_pipe[0] <= sin_arg;
    for (int i = 1; i < SINE_LAT - 1; i++) sin_pipe[i] <= sin_pipe[i-1];
  end
  always_comb sin_res = fsin(sin_pipe[SINE_LAT-2]);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkAllZero(input string name);
    logic any;
    any = |{busy, done, coef_valid, sin_en, coef_idx, coef_data, err_flags, mul_a, mul_b, sin_arg};
    checkOutput(name, 32'(any), 32'd0);
  endtask

  // Reference coefficient for offset n, with the OR of inexact flags of its multiplies.
  task automatic modelCoef(input logic [31:0] w, input int n, output logic [31:0] c, output logic fl);
    logic [31:0] arg, s, nf, hd;
    logic f1, f2;
    if (n == 0) begin
      tbMul(w, r2f(1.0 / PI), c, fl);
    end else begin
      nf = r2f(real'(n));
      hd = r2f(1.0 / (PI * real'(n)));
      tbMul(w, nf, arg, f1);
      s = fsin(arg);
      tbMul(s, hd, c, f2);
      fl = f1 | f2;
    end
  endtask

  // Push the expected stream for cutoff w, then pulse start for one cycle.
  task automatic applyStimulus(input logic [31:0] w);
    logic [31:0] c;
    logic fl;
    exp_err = 5'd0;
`ifdef FIR_SEQ_SYMMETRY_EN
    for (int n = -HALF; n <= 0; n++) begin
      modelCoef(w, n, c, fl);
      exp_err[0] = exp_err[0] | fl;
      sb.push_back('{idx: 4'(n + HALF), data: c});
      if (n != 0) sb.push_back('{idx: 4'(HALF - n), data: c});
    end
`else
    for (int n = -HALF; n <= HALF; n++) begin
      modelCoef(w, n, c, fl);
      exp_err[0] = exp_err[0] | fl;
      sb.push_back('{idx: 4'(n + HALF), data: c});
    end
`endif
    @(posedge clk); #1;
    w_c = w; start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    checkOutput("busy_in_start_cycle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; w_c = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Wait (bounded) for done, then check its timing, flags and scoreboard drain.
  task automatic waitDone();
    int waited = 0;
    bit seen = 1'b0;
    while (!seen && waited < 400) begin
      @(negedge clk);
      waited++;
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("done_cycle", 32'(cyc - start_cyc), 32'(EXP_DONE));
      checkOutput("busy_at_done", 32'(busy), 32'd1);
      checkOutput("err_flags", 32'(err_flags), 32'(exp_err));
      if (zero_mode) checkOutput("err_flags_zero_wc", 32'(err_flags), 32'd0);
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulseStartAt(input int ofs, input logic [31:0] w);
    while (cyc < start_cyc + ofs) @(posedge clk);
    #1; start = 1'b1; w_c = w;
    @(posedge clk); #1;
    start = 1'b0; w_c = 32'hDEADBEEF;
  endtask

  // Scoreboard consumer: every coef_valid strobe pops one expected record.
  always @(negedge clk) begin
    if (reset && coef_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_coef: got idx %0d data %h, required no strobe (cycle %0d)",
                 coef_idx, coef_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("coef_idx", 32'(coef_idx), 32'(e.idx));
        checkOutput("coef_data", coef_data, e.data);
        if (zero_mode) checkOutput("coef_zero_magnitude", {1'b0, coef_data[30:0]}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   done_cnt;
    logic bad;
    vecs[0] = '{w: 32'h3F5AD5F7, zero_run: 1'b0};
    vecs[1] = '{w: 32'h00000000, zero_run: 1'b1};
    vecs[2] = '{w: 32'h3F000000, zero_run: 1'b0};
    vecs[3] = '{w: 32'h3FC90FDB, zero_run: 1'b0};

    reset = 1'b0; start = 1'b0; w_c = 32'h0;
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset_state");
    @(posedge clk); #1 reset = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bad = bad | (|{busy, done, coef_valid, sin_en, coef_idx, coef_data, err_flags, mul_a, mul_b, sin_arg});
    end
    checkOutput("idle_without_start", 32'(bad), 32'd0);

    // Back-to-back runs: each start lands in the cycle after the previous done.
    for (int i = 0; i < 4; i++) begin
      zero_mode = vecs[i].zero_run;
      applyStimulus(vecs[i].w);
      waitDone();
      zero_mode = 1'b0;
    end
    @(negedge clk);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("done_single_pulse", 32'(done), 32'd0);

    // Starts during a run are ignored and do not re-latch w_c.
    applyStimulus(32'h3F5AD5F7);
    pulseStartAt(5, 32'h40000000);
    pulseStartAt(40, 32'h40400000);
    waitDone();
    @(negedge clk);
    checkOutput("no_restart_after_ignored", 32'(busy), 32'd0);

    // Reset during SIN of tap 3 aborts the run immediately.
    applyStimulus(32'h3F5AD5F7);
    while (cyc < start_cyc + RST_OFS) @(posedge clk);
    checkOutput("sin_en_before_abort", 32'(sin_en), 32'd1);
    #2 reset = 1'b0;
    #1 checkAllZero("reset_mid_run");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    done_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    checkOutput("no_done_after_abort", 32'(done_cnt), 32'd0);
    applyStimulus(32'h3F5AD5F7);
    waitDone();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
